// File: rtl/fsm_sequencer_pkg.sv
// Shared state encodings and instruction-length types for the cycle sequencer
// and the decode block that consumes its one-hot state.
package fsm_sequencer_pkg;

    localparam int         FSM_NUM_STATES      = 24;
    localparam logic [7:0] DEFAULT_HALT_OPCODE = 8'hAE;

    typedef logic [23:0] fsm_state_t;

    localparam fsm_state_t state_1  = 24'h000001;
    localparam fsm_state_t state_2  = 24'h000002;
    localparam fsm_state_t state_3  = 24'h000004;
    localparam fsm_state_t state_4  = 24'h000008;
    localparam fsm_state_t state_5  = 24'h000010;
    localparam fsm_state_t state_6  = 24'h000020;
    localparam fsm_state_t state_7  = 24'h000040;
    localparam fsm_state_t state_8  = 24'h000080;
    localparam fsm_state_t state_9  = 24'h000100;
    localparam fsm_state_t state_10 = 24'h000200;
    localparam fsm_state_t state_11 = 24'h000400;
    localparam fsm_state_t state_12 = 24'h000800;
    localparam fsm_state_t state_13 = 24'h001000;
    localparam fsm_state_t state_14 = 24'h002000;
    localparam fsm_state_t state_15 = 24'h004000;
    localparam fsm_state_t state_16 = 24'h008000;
    localparam fsm_state_t state_17 = 24'h010000;
    localparam fsm_state_t state_18 = 24'h020000;
    localparam fsm_state_t state_19 = 24'h040000;
    localparam fsm_state_t state_20 = 24'h080000;
    localparam fsm_state_t state_21 = 24'h100000;
    localparam fsm_state_t state_22 = 24'h200000;
    localparam fsm_state_t state_23 = 24'h400000;
    localparam fsm_state_t state_24 = 24'h800000;

    typedef enum logic [2:0] {
        LEN8  = 3'd0,
        LEN10 = 3'd1,
        LEN12 = 3'd2,
        LEN14 = 3'd3,
        LEN24 = 3'd4
    } inst_len_t;

    function automatic logic [4:0] len_count(input inst_len_t len);
        logic [4:0] cnt;
        case (len)
            LEN8:    cnt = 5'd8;
            LEN10:   cnt = 5'd10;
            LEN12:   cnt = 5'd12;
            LEN14:   cnt = 5'd14;
            LEN24:   cnt = 5'd24;
            default: cnt = 5'd8;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/fsm_sequencer_if.sv
// Control and status bundle between the front panel / instruction register
// and the cycle sequencer.
interface fsm_sequencer_if;
    import fsm_sequencer_pkg::*;

    logic       run;
    logic       step;
    logic       resume;
    logic [7:0] inst_reg_value;
    fsm_state_t state_onehot;
    logic       instr_done;
    logic       halted;
    logic       illegal_op;
    logic       seq_fault;

    modport master (
        output run, step, resume, inst_reg_value,
        input  state_onehot, instr_done, halted, illegal_op, seq_fault
    );

    modport slave (
        input  run, step, resume, inst_reg_value,
        output state_onehot, instr_done, halted, illegal_op, seq_fault
    );

endinterface

// File: rtl/fsm_sequencer_inst_length_decode.sv
// Maps an opcode to its cycle count class; also flags HALT and unknown opcodes.
module fsm_sequencer_inst_length_decode
    import fsm_sequencer_pkg::*;
#(
    parameter logic [7:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic [7:0] inst_reg_value,
    output inst_len_t  inst_len,
    output logic       is_halt,
    output logic       is_illegal
);

    // Opcode class decode; HALT is checked first so an overridden opcode still wins.
    always_comb begin
        inst_len   = LEN8;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (inst_reg_value == HALT_OPCODE) begin
            inst_len = LEN10;
            is_halt  = 1'b1;
        end else begin
            casez (inst_reg_value)
                8'b00??????: inst_len = LEN8;
                8'b01??????: inst_len = LEN8;
                8'b1000????: inst_len = LEN8;
                8'b1001????: inst_len = LEN12;
                8'b10100???: inst_len = LEN10;
                8'b10110000: inst_len = LEN14;
                8'b11??????: inst_len = LEN24;
                default: begin
                    inst_len   = LEN8;
                    is_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/fsm_sequencer.sv
// One-hot cycle sequencer: steps state_1..state_N per instruction, with
// HALT/resume, front-panel run/step and recovery from a corrupted state vector.
module fsm_sequencer
    import fsm_sequencer_pkg::*;
#(
    parameter int         NUM_STATES  = 24,
    parameter logic [7:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic            clk,
    input  logic            reset,
    fsm_sequencer_if.slave  bus
);

    if (NUM_STATES != FSM_NUM_STATES) begin : g_bad_num_states
        $error("fsm_sequencer: NUM_STATES must be 24");
    end

    fsm_state_t state_r, state_next_s;
    inst_len_t  len_r, len_next_s;
    logic       halt_op_r, halt_op_next_s;
    logic       instr_done_r, instr_done_next_s;
    logic       halted_r, halted_next_s;
    logic       illegal_r, illegal_next_s;
    logic       fault_r, fault_next_s;

    inst_len_t  dec_len_s;
    logic       dec_halt_s;
    logic       dec_illegal_s;
    logic       adv_s;
    logic [4:0] len_cnt_s;
    fsm_state_t wrap_mask_s;
    fsm_state_t above_mask_s;

    fsm_sequencer_inst_length_decode #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_len_dec (
        .inst_reg_value (bus.inst_reg_value),
        .inst_len       (dec_len_s),
        .is_halt        (dec_halt_s),
        .is_illegal     (dec_illegal_s)
    );

    assign adv_s        = !halted_r && (bus.run || bus.step);
    assign len_cnt_s    = len_count(len_r);
    assign wrap_mask_s  = 24'h000001 << (len_cnt_s - 5'd1);
    assign above_mask_s = 24'hFFFFFF << len_cnt_s;

    // Next-state, length latch and flag update.
    always_comb begin
        state_next_s      = state_r;
        len_next_s        = len_r;
        halt_op_next_s    = halt_op_r;
        instr_done_next_s = 1'b0;
        halted_next_s     = halted_r;
        illegal_next_s    = illegal_r;
        fault_next_s      = fault_r;
        if ($countones(state_r) != 32'd1) begin
            state_next_s = state_1;
            len_next_s   = LEN8;
            fault_next_s = 1'b1;
        end else if (halted_r) begin
            // resume only releases the freeze; the first advance is on the following edge
            halted_next_s = !bus.resume;
        end else if (adv_s) begin
            if ((state_r & above_mask_s) != 24'h000000) begin
                state_next_s = state_1;
                fault_next_s = 1'b1;
            end else if ((state_r & wrap_mask_s) != 24'h000000) begin
                state_next_s      = state_1;
                instr_done_next_s = 1'b1;
                halted_next_s     = halt_op_r;
            end else begin
                state_next_s = state_r << 1;
                if (state_r == state_3) begin
                    len_next_s     = dec_len_s;
                    halt_op_next_s = dec_halt_s;
                    illegal_next_s = illegal_r | dec_illegal_s;
                end else begin
                    len_next_s = len_r;
                end
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // State and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= state_1;
            len_r        <= LEN8;
            halt_op_r    <= 1'b0;
            instr_done_r <= 1'b0;
            halted_r     <= 1'b0;
            illegal_r    <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            len_r        <= len_next_s;
            halt_op_r    <= halt_op_next_s;
            instr_done_r <= instr_done_next_s;
            halted_r     <= halted_next_s;
            illegal_r    <= illegal_next_s;
            fault_r      <= fault_next_s;
        end
    end

    assign bus.state_onehot = state_r;
    assign bus.instr_done   = instr_done_r;
    assign bus.halted       = halted_r;
    assign bus.illegal_op   = illegal_r;
    assign bus.seq_fault    = fault_r;

endmodule
